grid_port_arbiter: RTL and testbench

- Arbitrates the single read port of the level map (grid) memory between NUM_REQ requesters: player updater, raycaster/renderer and sprite/enemy updater.
- Each requester presents grid coordinates and gets back the 3-bit cell type. 0 means empty; non-zero means wall or object.
- Requests are served one at a time with round-robin fairness, and the arbiter absorbs the memory read latency.
- Out-of-map coordinates are answered as solid without touching memory.

---
 rtl/grid_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_grid_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_port_arbiter.sv
// ---------------------------------------------------------------------------
// grid_port_arbiter
//
// Shares the single read port of the level-map (grid) memory between
// NUM_REQ requesters (player updater, raycaster/renderer, sprite updater).
// Requests are served one at a time. Round-robin order starts scanning at
// rr_ptr. The memory read latency is absorbed internally. Coordinates
// outside the map are answered as SOLID without a memory access.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   req         in   per-requester request level
//   req_grid_x  in   packed x coordinates, requester i at [6i+5:6i]
//   req_grid_y  in   packed y coordinates, requester i at [5i+4:5i]
//   ack         out  one-hot single-cycle pulse, rsp_data valid for winner
//   rsp_data    out  cell type of the last completed lookup (held)
//   busy        out  high whenever the arbiter is not idle
//   mem_rd_en   out  single-cycle read strobe to the map memory
//   mem_grid_x  out  registered x address to memory
//   mem_grid_y  out  registered y address to memory
//   mem_data    in   cell type returned by memory, MEM_LATENCY cycles later
// ---------------------------------------------------------------------------
module grid_port_arbiter #(
    parameter int         NUM_REQ     = 3,
    parameter int         MEM_LATENCY = 1,
    parameter int         MAP_W       = 40,
    parameter int         MAP_H       = 30,
    parameter logic [2:0] SOLID       = 3'b111
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [6*NUM_REQ-1:0] req_grid_x,
    input  logic [5*NUM_REQ-1:0] req_grid_y,
    output logic [NUM_REQ-1:0]   ack,
    output logic [2:0]           rsp_data,
    output logic                 busy,
    output logic                 mem_rd_en,
    output logic [5:0]           mem_grid_x,
    output logic [4:0]           mem_grid_y,
    input  logic [2:0]           mem_data
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RESPOND = 2'd3;

    // State and registered outputs
    logic [1:0]         state_q,     state_d;
    logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [IDX_W-1:0]   winner_q,    winner_d;
    logic [LAT_W-1:0]   lat_cnt_q,   lat_cnt_d;
    logic [NUM_REQ-1:0] ack_q,       ack_d;
    logic [2:0]         rsp_data_q,  rsp_data_d;
    logic               busy_q,      busy_d;
    logic               mem_rd_en_q, mem_rd_en_d;
    logic [5:0]         mem_x_q,     mem_x_d;
    logic [4:0]         mem_y_q,     mem_y_d;

    // Unpacked per-requester coordinates
    logic [5:0] req_x [NUM_REQ];
    logic [4:0] req_y [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_x[gi] = req_grid_x[6*gi +: 6];
            assign req_y[gi] = req_grid_y[5*gi +: 5];
        end
    endgenerate

    // Round-robin pick: first active request at or above rr_ptr, wrapping.
    logic             found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand_idx;
    int               cand;

    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found   = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    logic [5:0] win_x;
    logic [4:0] win_y;
    logic       win_out_of_range;

    assign win_x            = req_x[win_idx];
    assign win_y            = req_y[win_idx];
    assign win_out_of_range = (int'(win_x) >= MAP_W) || (int'(win_y) >= MAP_H);

    // Next-state logic. Outputs are registered, so each one is loaded on
    // the edge that enters the state in which it must be visible.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        winner_d    = winner_q;
        lat_cnt_d   = lat_cnt_q;
        ack_d       = '0;
        rsp_data_d  = rsp_data_q;
        mem_rd_en_d = 1'b0;
        mem_x_d     = mem_x_q;
        mem_y_d     = mem_y_q;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    winner_d = win_idx;
                    if (win_out_of_range) begin
                        // Answered locally; the memory address is left alone.
                        rsp_data_d     = SOLID;
                        ack_d[win_idx] = 1'b1;
                        state_d        = ST_RESPOND;
                    end else begin
                        // Coordinates are latched here so later changes on
                        // the request bus cannot disturb the access.
                        mem_rd_en_d = 1'b1;
                        mem_x_d     = win_x;
                        mem_y_d     = win_y;
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                lat_cnt_d = LAT_W'(MEM_LATENCY - 1);
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt_q == '0) begin
                    rsp_data_d      = mem_data;
                    ack_d[winner_q] = 1'b1;
                    state_d         = ST_RESPOND;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            ST_RESPOND: begin
                rr_ptr_d = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            winner_q    <= '0;
            lat_cnt_q   <= '0;
            ack_q       <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_x_q     <= '0;
            mem_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            winner_q    <= winner_d;
            lat_cnt_q   <= lat_cnt_d;
            ack_q       <= ack_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_x_q     <= mem_x_d;
            mem_y_q     <= mem_y_d;
        end
    end

    assign ack        = ack_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = busy_q;
    assign mem_rd_en  = mem_rd_en_q;
    assign mem_grid_x = mem_x_q;
    assign mem_grid_y = mem_y_q;

endmodule

// File: tb/tb_grid_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_grid_port_arbiter
//
// Directed bench for grid_port_arbiter. Two instances share one clock:
// dut_a with MEM_LATENCY=1 and dut_b with MEM_LATENCY=3. Each has a small
// map-memory model returning (x ^ y)[2:0] exactly MEM_LATENCY cycles after
// the read strobe, and 0 in every other cycle. Inputs are driven 1 time
// unit after the rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_grid_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- dut_a (MEM_LATENCY = 1) ----------------
    logic        a_reset;
    logic [2:0]  a_req;
    logic [17:0] a_x;
    logic [14:0] a_y;
    logic [2:0]  a_ack;
    logic [2:0]  a_rsp;
    logic        a_busy;
    logic        a_rd;
    logic [5:0]  a_mx;
    logic [4:0]  a_my;
    logic [2:0]  a_md;

    grid_port_arbiter #(
        .NUM_REQ(3), .MEM_LATENCY(1), .MAP_W(40), .MAP_H(30), .SOLID(3'b111)
    ) dut_a (
        .clock(clk), .reset(a_reset), .req(a_req),
        .req_grid_x(a_x), .req_grid_y(a_y),
        .ack(a_ack), .rsp_data(a_rsp), .busy(a_busy),
        .mem_rd_en(a_rd), .mem_grid_x(a_mx), .mem_grid_y(a_my),
        .mem_data(a_md)
    );

    logic       a_vld;
    logic [2:0] a_val;
    always @(posedge clk) begin
        a_vld <= a_rd;
        a_val <= a_mx[2:0] ^ {1'b0, a_my[1:0]} ^ {a_my[2], 2'b00};
    end
    assign a_md = a_vld ? a_val : 3'b000;

    // ---------------- dut_b (MEM_LATENCY = 3) ----------------
    logic        b_reset;
    logic [2:0]  b_req;
    logic [17:0] b_x;
    logic [14:0] b_y;
    logic [2:0]  b_ack;
    logic [2:0]  b_rsp;
    logic        b_busy;
    logic        b_rd;
    logic [5:0]  b_mx;
    logic [4:0]  b_my;
    logic [2:0]  b_md;

    grid_port_arbiter #(
        .NUM_REQ(3), .MEM_LATENCY(3), .MAP_W(40), .MAP_H(30), .SOLID(3'b111)
    ) dut_b (
        .clock(clk), .reset(b_reset), .req(b_req),
        .req_grid_x(b_x), .req_grid_y(b_y),
        .ack(b_ack), .rsp_data(b_rsp), .busy(b_busy),
        .mem_rd_en(b_rd), .mem_grid_x(b_mx), .mem_grid_y(b_my),
        .mem_data(b_md)
    );

    logic       b_vld [3];
    logic [2:0] b_val [3];
    always @(posedge clk) begin
        b_vld[0] <= b_rd;
        b_val[0] <= b_mx[2:0] ^ b_my[2:0];
        for (int k = 1; k < 3; k++) begin
            b_vld[k] <= b_vld[k-1];
            b_val[k] <= b_val[k-1];
        end
    end
    assign b_md = b_vld[2] ? b_val[2] : 3'b000;

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_xy(input bit sel, input int idx, input logic [5:0] x, input logic [4:0] y);
        if (sel) begin
            b_x[idx*6 +: 6] = x;
            b_y[idx*5 +: 5] = y;
        end else begin
            a_x[idx*6 +: 6] = x;
            a_y[idx*5 +: 5] = y;
        end
    endtask

    // Waits (bounded) for the next ack pulse; n counts cycles from the call.
    task automatic wait_ack(input bit sel, input int budget, output int n,
                            output bit rd_seen, output logic [2:0] ack_v,
                            output logic [2:0] rsp_v);
        n       = 0;
        rd_seen = 1'b0;
        ack_v   = 3'b000;
        rsp_v   = 3'b000;
        for (int i = 1; i <= budget; i++) begin
            step();
            n = i;
            if (sel ? b_rd : a_rd) rd_seen = 1'b1;
            if ((sel ? b_ack : a_ack) != 3'b000) begin
                ack_v = sel ? b_ack : a_ack;
                rsp_v = sel ? b_rsp : a_rsp;
                break;
            end
        end
        $display("txn dut_%s ack=%b rsp=%0d cycles=%0d mem_access=%0d",
                 sel ? "b" : "a", ack_v, rsp_v, n, rd_seen);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    int         n;
    bit         rd_seen;
    logic [2:0] ackv;
    logic [2:0] rspv;
    logic [2:0] ack_or;
    logic [2:0] rr_ack [4];
    logic [2:0] rr_rsp [4];
    int         rr_n   [4];

    initial begin
        a_reset = 1'b1; b_reset = 1'b1;
        a_req = '0; b_req = '0;
        a_x = '0; a_y = '0; b_x = '0; b_y = '0;
        step();
        step();

        // Reset values
        check("rst_ack",   {29'd0, a_ack}, 32'd0);
        check("rst_busy",  {31'd0, a_busy}, 32'd0);
        check("rst_rd",    {31'd0, a_rd}, 32'd0);
        check("rst_rsp",   {29'd0, a_rsp}, 32'd0);
        check("rst_addr",  {21'd0, a_mx, a_my}, 32'd0);
        check("rst_b_ack", {29'd0, b_ack}, 32'd0);
        a_reset = 1'b0; b_reset = 1'b0;
        step();

        // Single request, latency 1: (5,7) -> 5^7 = 2
        set_xy(0, 0, 6'd5, 5'd7);
        a_req = 3'b001;
        step();
        check("single_rd_t1",   {31'd0, a_rd}, 32'd1);
        check("single_addr_t1", {21'd0, a_mx, a_my}, {21'd0, 6'd5, 5'd7});
        check("single_busy_t1", {31'd0, a_busy}, 32'd1);
        check("single_ack_t1",  {29'd0, a_ack}, 32'd0);
        step();
        check("single_rd_t2",   {31'd0, a_rd}, 32'd0);
        check("single_addr_t2", {21'd0, a_mx, a_my}, {21'd0, 6'd5, 5'd7});
        check("single_ack_t2",  {29'd0, a_ack}, 32'd0);
        step();
        check("single_ack_t3",  {29'd0, a_ack}, 32'd1);
        check("single_rsp_t3",  {29'd0, a_rsp}, 32'd2);
        $display("txn dut_a single ack=%b rsp=%0d", a_ack, a_rsp);
        a_req = 3'b000;
        step();
        check("single_ack_t4",  {29'd0, a_ack}, 32'd0);
        check("single_busy_t4", {31'd0, a_busy}, 32'd0);
        check("single_rsp_hold", {29'd0, a_rsp}, 32'd2);

        // Round robin from rr_ptr=0 with all three requests held
        a_reset = 1'b1;
        step();
        a_reset = 1'b0;
        check("rr_rst_rsp", {29'd0, a_rsp}, 32'd0);
        set_xy(0, 0, 6'd1, 5'd2);   // 3
        set_xy(0, 1, 6'd3, 5'd5);   // 6
        set_xy(0, 2, 6'd4, 5'd1);   // 5
        rr_ack = '{3'b001, 3'b010, 3'b100, 3'b001};
        rr_rsp = '{3'd3, 3'd6, 3'd5, 3'd3};
        rr_n   = '{3, 4, 4, 4};
        a_req  = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_ack(1'b0, 10, n, rd_seen, ackv, rspv);
            check($sformatf("rr_ack_%0d", i), {29'd0, ackv}, {29'd0, rr_ack[i]});
            check($sformatf("rr_rsp_%0d", i), {29'd0, rspv}, {29'd0, rr_rsp[i]});
            check($sformatf("rr_lat_%0d", i), n, rr_n[i]);
        end
        a_req = 3'b000;
        step();
        check("rr_idle", {31'd0, a_busy}, 32'd0);

        // Out of range x = MAP_W
        set_xy(0, 1, 6'd40, 5'd0);
        a_req = 3'b010;
        wait_ack(1'b0, 10, n, rd_seen, ackv, rspv);
        check("oor_x_ack", {29'd0, ackv}, 32'b010);
        check("oor_x_rsp", {29'd0, rspv}, 32'd7);
        check("oor_x_lat", n, 1);
        check("oor_x_nomem", {31'd0, rd_seen}, 32'd0);
        a_req = 3'b000;
        step();

        // Corner in range (39,29) -> 39^29 low bits = 2
        set_xy(0, 1, 6'd39, 5'd29);
        a_req = 3'b010;
        wait_ack(1'b0, 10, n, rd_seen, ackv, rspv);
        check("edge_ack", {29'd0, ackv}, 32'b010);
        check("edge_rsp", {29'd0, rspv}, 32'd2);
        check("edge_lat", n, 3);
        check("edge_mem", {31'd0, rd_seen}, 32'd1);
        check("edge_addr", {21'd0, a_mx, a_my}, {21'd0, 6'd39, 5'd29});
        a_req = 3'b000;
        step();

        // Out of range y = MAP_H
        set_xy(0, 2, 6'd0, 5'd30);
        a_req = 3'b100;
        wait_ack(1'b0, 10, n, rd_seen, ackv, rspv);
        check("oor_y_ack", {29'd0, ackv}, 32'b100);
        check("oor_y_rsp", {29'd0, rspv}, 32'd7);
        check("oor_y_lat", n, 1);
        check("oor_y_nomem", {31'd0, rd_seen}, 32'd0);
        a_req = 3'b000;
        step();

        // Out of range at the top of both fields
        set_xy(0, 0, 6'd63, 5'd31);
        a_req = 3'b001;
        wait_ack(1'b0, 10, n, rd_seen, ackv, rspv);
        check("oor_max_ack", {29'd0, ackv}, 32'b001);
        check("oor_max_lat", n, 1);
        check("oor_max_addr", {21'd0, a_mx, a_my}, {21'd0, 6'd39, 5'd29});
        a_req = 3'b000;
        step();

        // Latency 3; x changes after the request is latched: (9,20) -> 5
        set_xy(1, 0, 6'd9, 5'd20);
        b_req = 3'b001;
        step();
        check("lat3_rd", {31'd0, b_rd}, 32'd1);
        check("lat3_addr", {21'd0, b_mx, b_my}, {21'd0, 6'd9, 5'd20});
        set_xy(1, 0, 6'd0, 5'd20);
        wait_ack(1'b1, 10, n, rd_seen, ackv, rspv);
        check("lat3_ack", {29'd0, ackv}, 32'b001);
        check("lat3_rsp", {29'd0, rspv}, 32'd5);
        check("lat3_lat", n + 1, 5);
        b_req = 3'b000;
        step();

        // Reset while waiting on memory (requester 1, rr_ptr=1 beforehand)
        set_xy(1, 1, 6'd17, 5'd10);
        b_req = 3'b010;
        step();
        step();
        check("abort_busy_pre", {31'd0, b_busy}, 32'd1);
        b_reset = 1'b1;
        b_req   = 3'b000;
        step();
        b_reset = 1'b0;
        check("abort_ack",  {29'd0, b_ack}, 32'd0);
        check("abort_busy", {31'd0, b_busy}, 32'd0);
        check("abort_rd",   {31'd0, b_rd}, 32'd0);
        check("abort_rsp",  {29'd0, b_rsp}, 32'd0);
        ack_or = 3'b000;
        for (int i = 0; i < 5; i++) begin
            step();
            ack_or = ack_or | b_ack;
        end
        check("abort_no_ack", {29'd0, ack_or}, 32'd0);

        // rr_ptr back to 0: requester 0 wins over 2, then 2 is served
        set_xy(1, 0, 6'd6, 5'd3);   // 5
        set_xy(1, 2, 6'd2, 5'd6);   // 4
        b_req = 3'b101;
        wait_ack(1'b1, 12, n, rd_seen, ackv, rspv);
        check("post_rst_ack0", {29'd0, ackv}, 32'b001);
        check("post_rst_rsp0", {29'd0, rspv}, 32'd5);
        check("post_rst_lat0", n, 5);
        wait_ack(1'b1, 12, n, rd_seen, ackv, rspv);
        check("post_rst_ack2", {29'd0, ackv}, 32'b100);
        check("post_rst_rsp2", {29'd0, rspv}, 32'd4);
        check("post_rst_lat2", n, 6);
        b_req = 3'b000;
        step();

        // Requester 0 drops req while waiting; requester 1 is pending
        set_xy(1, 0, 6'd17, 5'd10);  // 3
        set_xy(1, 1, 6'd39, 5'd29);  // 2
        b_req = 3'b001;
        step();
        step();
        b_req = 3'b010;
        wait_ack(1'b1, 12, n, rd_seen, ackv, rspv);
        check("drop_ack0", {29'd0, ackv}, 32'b001);
        check("drop_rsp0", {29'd0, rspv}, 32'd3);
        check("drop_lat0", n, 3);
        wait_ack(1'b1, 12, n, rd_seen, ackv, rspv);
        check("drop_ack1", {29'd0, ackv}, 32'b010);
        check("drop_rsp1", {29'd0, rspv}, 32'd2);
        check("drop_lat1", n, 6);
        b_req = 3'b000;
        step();
        check("drop_idle", {31'd0, b_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
